// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, opcodes, ALU operation codes, mux select codes and the
// control word produced by the state decoder.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_EXEC_I   = 4'd11,
        S_WB_I     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_FUNCT = 3'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decoder from FSM state to datapath control word.
// mem_ready only qualifies the instruction/PC latch during FETCH.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    // Control word per state; everything not named stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SL;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RT;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_RT;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_JUMP;
            end
            S_WB_I: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Optional performance counters (instr_cnt, stall_cnt) are built when
// MIPS_CTRL_PERF_CNT_EN is defined.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              mem_to_reg,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_src,
    output logic              illegal,
    output logic [3:0]        state_o
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_illegal;
    logic [5:0] w_op;
    ctrl_t      w_ctrl;
    logic       w_unused_zero;

    assign w_op          = 6'(opcode);
    // zero is consumed by the datapath's PC-load gating, not by the FSM
    assign w_unused_zero = zero;

    // State register and sticky illegal flag; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state selection from current state, opcode and mem_ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_RTYPE:     w_state_nxt = S_EXEC_R;
                    OP_LW, OP_SW: w_state_nxt = S_MEM_ADDR;
                    OP_BEQ:       w_state_nxt = S_BRANCH;
                    OP_J:         w_state_nxt = S_JUMP;
                    OP_ADDI:      w_state_nxt = S_EXEC_I;
                    default:      w_state_nxt = S_HALT;
                endcase
            end
            S_EXEC_R:   w_state_nxt = S_WB_R;
            S_MEM_ADDR: w_state_nxt = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_state_nxt = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) w_state_nxt = S_FETCH;
            S_EXEC_I:   w_state_nxt = S_WB_I;
            S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_WB_I:
                        w_state_nxt = S_FETCH;
            S_HALT:     w_state_nxt = S_HALT;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = ALUOPW'(w_ctrl.alu_op);
    assign pc_src        = w_ctrl.pc_src;
    assign illegal       = r_illegal;
    assign state_o       = r_state;

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] r_instr_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_retire;
    logic        w_stall;

    // An instruction retires whenever a terminal state hands back to FETCH.
    assign w_retire = (w_state_nxt == S_FETCH) && (r_state != S_IDLE)
                      && (r_state != S_FETCH);
    assign w_stall  = !mem_ready && ((r_state == S_FETCH) ||
                      (r_state == S_MEM_RD) || (r_state == S_MEM_WR));

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
            if (w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
